reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
- Decode-stage register scoreboard that produces the per-operand hazard flags `bubble1`/`bubble2` consumed by the operand/immediate-select logic.
- Tracks in-flight writes to the 32 GPRs, from issue at decode to retire at writeback or squash by flush.
- Sits beside the register file. Receives the issue handshake from decode and retire/kill notifications from the back end.

Parameters:
CNT_W, 2, width of each per-register pending counter (max in-flight writes per register = 2^CNT_W-1)
NREG, 32, number of architectural registers (x0 hardwired, never pending)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ra1  input  5  source register 1 of the instruction in decode
ra2  input  5  source register 2 of the instruction in decode
issue_valid  input  1  decode issues an instruction that writes issue_rd
issue_rd  input  5  destination of issuing instruction
issue_ready  output  1  scoreboard can accept the issue this cycle
retire_valid  input  1  writeback commits a register write
retire_rd  input  5  register being written back
kill_valid  input  1  an in-flight writing instruction was squashed
kill_rd  input  5  destination of squashed instruction
bubble1  output  1  ra1 has a pending write
bubble2  output  1  ra2 has a pending write
pending_mask  output  32  bit i = counter i nonzero
busy  output  1  any register pending
err  output  1  sticky: retire/kill hit a zero counter

Behaviour:
- State: NREG counters of CNT_W bits plus the sticky err flag. Counter 0 is held at 0 permanently.
- Reset (synchronous, reset=1 at edge): all counters 0, err=0. After reset: bubble1=bubble2=0, pending_mask=0, busy=0, issue_ready=1. Reset mid-operation discards all pending state that cycle; inputs sampled in that same cycle are ignored.
- bubble1 = (ra1!=0) & (cnt[ra1]!=0). bubble2 likewise for ra2. Both are combinational from current state; zero latency.
- issue_ready = (issue_rd==0) | (cnt[issue_rd] != max) | (retire or kill decrements issue_rd this cycle).
- An issue takes effect only when issue_valid & issue_ready. issue_rd==0 is accepted with no state change.
- Per-register next value: cnt + inc - dec_r - dec_k, where:
  - inc = accepted issue to this register.
  - dec_r = retire_valid & retire_rd==i.
  - dec_k = kill_valid & kill_rd==i.
- Retire and kill may target the same register in one cycle. The net decrement is 2.
- Simultaneous issue and retire to the same register gives a net-zero change. Same-cycle issue+retire never bubbles the issuing instruction itself, since it reads pre-update state.
- Underflow: if total decrements exceed cnt+inc, the counter clamps to 0 and err sets. err is sticky until reset. Decrements targeting x0 are ignored and do not set err.
- Overflow is impossible: issue_ready gating prevents it.
- pending_mask[i] = cnt[i]!=0. busy = |pending_mask.

Optional Feature:
- SCB_BYPASS_EN:
  - Defined: a source whose counter is exactly 1 and is retired this same cycle (retire_valid & retire_rd==raN) reports bubbleN=0. The writeback value is forwarded externally.
  - Extra outputs byp1, byp2 (1 bit each) assert exactly in that case.
  - A kill of that register in the same cycle cancels the bypass: bubble stays 1, bypN=0.
- Undefined: bubble depends on the counter only; byp1/byp2 are absent.

Test Plan:
- Reset, then ra1=5, ra2=6 with no activity -> bubble1=0, bubble2=0, busy=0, issue_ready=1, err=0.
- Issue rd=5 at cycle 0; ra1=5 from cycle 1 -> bubble1=1, pending_mask=0x20. Retire rd=5 at cycle 3 -> bubble1=0 at cycle 4. Bypass build: bubble1=0 and byp1=1 during cycle 3.
- With CNT_W=2, issue rd=7 three times -> issue_ready=0 for issue_rd=7. Fourth issue with simultaneous retire rd=7 -> accepted, counter stays 3.
- Issue rd=0 and ra1=0 -> no state change, bubble1=0, busy=0. Retire rd=0 -> err stays 0.
- cnt[9]=1; kill rd=9 and retire rd=9 in the same cycle -> counter 0, err=1, err stays 1 until reset.
- Issue rd=4 and rd=8, then assert reset while both are pending -> next cycle pending_mask=0, bubble1=bubble2=0 for ra1=4, ra2=8.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: decode-stage GPR write scoreboard producing per-operand hazard bubbles; optional SCB_BYPASS_EN forwards same-cycle retires
module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            retire_valid,
  input  logic [4:0]      retire_rd,
  input  logic            kill_valid,
  input  logic [4:0]      kill_rd,
  output logic            bubble1,
  output logic            bubble2,
  output logic [NREG-1:0] pending_mask,
  output logic            busy,
  output logic            err
`ifdef SCB_BYPASS_EN
  ,
  output logic            byp1,
  output logic            byp2
`endif
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0] under;
  logic err_q, err_d;
  logic pend1, pend2;
  assign issue_ready = issue_rd == 5'd0 || cnt_q[issue_rd] != CMAX ||
                       (retire_valid && retire_rd == issue_rd) || (kill_valid && kill_rd == issue_rd);
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic inc, dr, dk;
    logic [CNT_W:0] tot, dec;
    assign inc = r != 0 && issue_valid && issue_ready && issue_rd == 5'(r);
    assign dr = r != 0 && retire_valid && retire_rd == 5'(r);
    assign dk = r != 0 && kill_valid && kill_rd == 5'(r);
    assign tot = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
    assign dec = (CNT_W+1)'(dr) + (CNT_W+1)'(dk);
    assign under[r] = dec > tot;
    assign cnt_d[r] = under[r] ? '0 : CNT_W'(tot - dec);
    assign pending_mask[r] = cnt_q[r] != '0;
  end
  assign err_d = err_q | (|under);
  // counters and sticky error; reset discards everything sampled this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign pend1 = ra1 != 5'd0 && cnt_q[ra1] != '0;
  assign pend2 = ra2 != 5'd0 && cnt_q[ra2] != '0;
  assign busy = |pending_mask;
  assign err = err_q;
`ifdef SCB_BYPASS_EN
  assign byp1 = pend1 && cnt_q[ra1] == CNT_W'(1) && retire_valid && retire_rd == ra1 && !(kill_valid && kill_rd == ra1);
  assign byp2 = pend2 && cnt_q[ra2] == CNT_W'(1) && retire_valid && retire_rd == ra2 && !(kill_valid && kill_rd == ra2);
  assign bubble1 = pend1 && !byp1;
  assign bubble2 = pend2 && !byp2;
`else
  assign bubble1 = pend1;
  assign bubble2 = pend2;
`endif
endmodule
